// File: rtl/pong_game_core.sv
// Pong engine: paddle and ball motion, serve/score FSM and pixel colouring.
// All game state advances on a single per-frame tick taken from the scan position.
module pong_game_core #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int PAD_HEIGHT   = 72,
    parameter int PAD_WIDTH    = 8,
    parameter int P1_X         = 32,
    parameter int P2_X         = 600,
    parameter int BALL_SIZE    = 8,
    parameter int PAD_VEL      = 3,
    parameter int BALL_VEL     = 2,
    parameter int WIN_SCORE    = 9,
    parameter int SCORE_W      = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               up1,
    input  logic               down1,
    input  logic               up2,
    input  logic               down2,
    input  logic               start,
    input  logic               video_on,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic [11:0]        rgb,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               game_over,
    output logic               winner
);
    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

    localparam int TW = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0] FRAME_Y   = 10'(V_ACTIVE + 1);
    localparam logic [9:0] PAD_MAX   = 10'(V_ACTIVE - PAD_HEIGHT);
    localparam logic [9:0] PAD_INIT  = 10'((V_ACTIVE - PAD_HEIGHT) / 2);
    localparam logic [9:0] BALL_X0   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_YMAX = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] PV        = 10'(PAD_VEL);
    localparam logic [9:0] BV        = 10'(BALL_VEL);
    localparam logic [9:0] PH        = 10'(PAD_HEIGHT);
    localparam logic [9:0] PW        = 10'(PAD_WIDTH);
    localparam logic [9:0] BS        = 10'(BALL_SIZE);
    localparam logic [9:0] P1_HIT_LO = 10'(P1_X);
    localparam logic [9:0] P1_HIT_HI = 10'(P1_X + PAD_WIDTH - 1);
    localparam logic [9:0] P1_RET    = 10'(P1_X + PAD_WIDTH);
    // Paddle 2 is hit by the ball's right edge, expressed here as left-edge bounds.
    localparam logic [9:0] P2_HIT_LO = 10'(P2_X - BALL_SIZE + 1);
    localparam logic [9:0] P2_HIT_HI = 10'(P2_X + PAD_WIDTH - BALL_SIZE);
    localparam logic [9:0] P2_RET    = 10'(P2_X - BALL_SIZE);
    localparam logic [9:0] R_MISS_TH = 10'(H_ACTIVE - BALL_SIZE - BALL_VEL);
    localparam logic [9:0] NET_X0    = 10'(H_ACTIVE / 2 - 1);
    localparam logic [9:0] NET_X1    = 10'(H_ACTIVE / 2);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [TW-1:0]      SF_LAST = TW'(SERVE_FRAMES - 1);

    state_t             state_q, state_d;
    logic [9:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic               x_dir_q, x_dir_d, y_dir_q, y_dir_d;  // 1 = right / down
    logic [TW-1:0]      serve_cnt_q, serve_cnt_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic               game_over_q, game_over_d, winner_q, winner_d;

    logic               frame_tick, pad_move;
    logic [1:0]         btn_up, btn_dn, pad_px;
    logic [9:0]         pad_top [2];
    logic               hit1, hit2, miss_l, miss_r, ball_px, net_px;
    logic               p1_point, p2_point;
    logic [SCORE_W-1:0] p1_inc, p2_inc;

    assign frame_tick = (x == 10'd0) && (y == FRAME_Y);
    assign pad_move   = frame_tick && (state_q == S_SERVE || state_q == S_PLAY);
    assign btn_up     = {up2, up1};
    assign btn_dn     = {down2, down1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pad
            localparam logic [9:0] PX = (gi == 0) ? 10'(P1_X) : 10'(P2_X);
            logic [9:0] top_q, top_d;

            always_comb begin
                top_d = top_q;
                if (pad_move) begin
                    if (btn_up[gi] && !btn_dn[gi])
                        top_d = (top_q <= PV) ? 10'd0 : top_q - PV;
                    else if (btn_dn[gi] && !btn_up[gi])
                        top_d = (top_q >= PAD_MAX - PV) ? PAD_MAX : top_q + PV;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) top_q <= PAD_INIT;
                else       top_q <= top_d;
            end

            assign pad_top[gi] = top_q;
            assign pad_px[gi]  = (x >= PX) && (x < PX + PW) && (y >= top_q) && (y < top_q + PH);
        end
    endgenerate

    assign miss_l = (ball_x_q < BV);
    assign miss_r = (ball_x_q > R_MISS_TH);
    assign hit1   = (ball_x_q >= P1_HIT_LO) && (ball_x_q <= P1_HIT_HI)
                 && (ball_y_q + BS > pad_top[0]) && (ball_y_q < pad_top[0] + PH);
    assign hit2   = (ball_x_q >= P2_HIT_LO) && (ball_x_q <= P2_HIT_HI)
                 && (ball_y_q + BS > pad_top[1]) && (ball_y_q < pad_top[1] + PH);
    assign p1_inc = (p1_score_q == '1) ? p1_score_q : p1_score_q + SCORE_W'(1);
    assign p2_inc = (p2_score_q == '1) ? p2_score_q : p2_score_q + SCORE_W'(1);

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        x_dir_d     = x_dir_q;
        y_dir_d     = y_dir_q;
        serve_cnt_d = serve_cnt_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        p1_point    = 1'b0;
        p2_point    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d     = S_SERVE;
                serve_cnt_d = '0;
                x_dir_d     = 1'b1;
                y_dir_d     = 1'b1;
            end
            S_SERVE: if (frame_tick) begin
                if (serve_cnt_q == SF_LAST) begin
                    state_d     = S_PLAY;
                    serve_cnt_d = '0;
                end else begin
                    serve_cnt_d = serve_cnt_q + TW'(1);
                end
            end
            S_PLAY: if (frame_tick) begin
                if (!x_dir_q) begin
                    if (miss_l)    p2_point = 1'b1;
                    else if (hit1) begin ball_x_d = P1_RET; x_dir_d = 1'b1; end
                    else           ball_x_d = ball_x_q - BV;
                end else begin
                    if (miss_r)    p1_point = 1'b1;
                    else if (hit2) begin ball_x_d = P2_RET; x_dir_d = 1'b0; end
                    else           ball_x_d = ball_x_q + BV;
                end
                if (y_dir_q) begin
                    if (ball_y_q >= BALL_YMAX - BV) begin ball_y_d = BALL_YMAX; y_dir_d = 1'b0; end
                    else ball_y_d = ball_y_q + BV;
                end else begin
                    if (ball_y_q <= BV) begin ball_y_d = 10'd0; y_dir_d = 1'b1; end
                    else ball_y_d = ball_y_q - BV;
                end
                if (p1_point || p2_point) begin
                    // Re-centre and serve toward whoever just conceded.
                    ball_x_d    = BALL_X0;
                    ball_y_d    = BALL_Y0;
                    x_dir_d     = p1_point;
                    y_dir_d     = 1'b1;
                    serve_cnt_d = '0;
                    if (p1_point) p1_score_d = p1_inc;
                    else          p2_score_d = p2_inc;
                    if ((p1_point && p1_inc == WIN) || (p2_point && p2_inc == WIN)) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = p2_point;
                    end else begin
                        state_d = S_SERVE;
                    end
                end
            end
            S_OVER: if (start) begin
                state_d     = S_SERVE;
                serve_cnt_d = '0;
                x_dir_d     = 1'b1;
                y_dir_d     = 1'b1;
                p1_score_d  = '0;
                p2_score_d  = '0;
                game_over_d = 1'b0;
                winner_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            x_dir_q     <= 1'b1;
            y_dir_q     <= 1'b1;
            serve_cnt_q <= '0;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            x_dir_q     <= x_dir_d;
            y_dir_q     <= y_dir_d;
            serve_cnt_q <= serve_cnt_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign ball_px = (x >= ball_x_q) && (x < ball_x_q + BS) && (y >= ball_y_q) && (y < ball_y_q + BS);
    assign net_px  = ((x == NET_X0) || (x == NET_X1)) && !y[4];

    always_comb begin
        rgb = 12'h111;
        if (!video_on)    rgb = 12'h000;
        else if (|pad_px) rgb = 12'hAAA;
        else if (ball_px) rgb = 12'hFFF;
        else if (net_px)  rgb = 12'h555;
    end

    assign p1_score  = p1_score_q;
    assign p2_score  = p2_score_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
endmodule

// File: tb/tb_pong_game_core.sv
// Directed bench for pong_game_core: pixel table after reset, then scripted rallies
// whose ball positions, hits and points are worked out by hand from the geometry.
module tb_pong_game_core;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
    logic       start = 1'b0;
    logic       video_on = 1'b0;
    logic [9:0] x = 10'd1, y = 10'd0;
    logic [11:0] rgb;
    logic [3:0] p1_score, p2_score;
    logic       game_over, winner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pong_game_core dut (
        .clk(clk), .reset(reset),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .start(start), .video_on(video_on), .x(x), .y(y),
        .rgb(rgb), .p1_score(p1_score), .p2_score(p2_score),
        .game_over(game_over), .winner(winner)
    );

    typedef struct {
        logic        vo;
        int          px;
        int          py;
        logic [11:0] exp;
    } pix_vec_t;

    pix_vec_t vecs [20];

    // One clock edge with the scan at (0, V_ACTIVE+1): exactly one frame tick.
    task automatic tick();
        @(negedge clk);
        video_on = 1'b0; x = 10'd0; y = 10'd481;
        @(negedge clk);
        x = 10'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        x = 10'd1; y = 10'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic probe(input logic vo, input int px, input int py, output logic [11:0] c);
        video_on = vo; x = 10'(px); y = 10'(py);
        #1;
        c = rgb;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic check_ball(input string name, input int bx, input int by);
        logic [11:0] c0, c1, c2, c3;
        probe(1'b1, bx, by, c0);
        probe(1'b1, bx + 7, by + 7, c1);
        probe(1'b1, bx - 1, by, c2);
        probe(1'b1, bx, by - 1, c3);
        total++;
        if (!(c0 == 12'hFFF && c1 == 12'hFFF && c2 != 12'hFFF && c3 != 12'hFFF)) begin
            bad++;
            $display("FAIL %s: ball expected at (%0d,%0d), rgb corner=%h far=%h left=%h above=%h",
                     name, bx, by, c0, c1, c2, c3);
        end else begin
            $display("ok   %s ball at (%0d,%0d)", name, bx, by);
        end
    endtask

    task automatic check_pad(input string name, input int side, input int top);
        logic [11:0] c0, c1, c2, c3;
        int px;
        px = (side == 0) ? 32 : 600;
        probe(1'b1, px, top, c0);
        probe(1'b1, px + 7, top + 71, c1);
        probe(1'b1, px, top - 1, c2);
        probe(1'b1, px, top + 72, c3);
        total++;
        if (!(c0 == 12'hAAA && c1 == 12'hAAA && c2 != 12'hAAA && c3 != 12'hAAA)) begin
            bad++;
            $display("FAIL %s: paddle %0d expected top %0d, rgb top=%h bottom=%h above=%h below=%h",
                     name, side + 1, top, c0, c1, c2, c3);
        end else begin
            $display("ok   %s paddle %0d top %0d", name, side + 1, top);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] c;

        // Reset-state pixel table: paddles rows 204..275, ball 316..323 x 236..243.
        vecs[0]  = '{1'b1, 320, 240, 12'hFFF};
        vecs[1]  = '{1'b0, 320, 240, 12'h000};
        vecs[2]  = '{1'b1,  32, 204, 12'hAAA};
        vecs[3]  = '{1'b1,  39, 275, 12'hAAA};
        vecs[4]  = '{1'b1,  31, 204, 12'h111};
        vecs[5]  = '{1'b1,  32, 203, 12'h111};
        vecs[6]  = '{1'b1,  32, 276, 12'h111};
        vecs[7]  = '{1'b1, 600, 204, 12'hAAA};
        vecs[8]  = '{1'b1, 607, 250, 12'hAAA};
        vecs[9]  = '{1'b1, 608, 250, 12'h111};
        vecs[10] = '{1'b1, 319,   0, 12'h555};
        vecs[11] = '{1'b1, 320,  15, 12'h555};
        vecs[12] = '{1'b1, 319,  16, 12'h111};
        vecs[13] = '{1'b1, 321,   0, 12'h111};
        vecs[14] = '{1'b1, 319, 236, 12'hFFF};
        vecs[15] = '{1'b1, 315, 236, 12'h111};
        vecs[16] = '{1'b1, 324, 243, 12'h111};
        vecs[17] = '{1'b1, 316, 244, 12'h111};
        vecs[18] = '{1'b1, 323, 243, 12'hFFF};
        vecs[19] = '{1'b0,  32, 204, 12'h000};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_val("reset_p1_score", int'(p1_score), 0);
        check_val("reset_p2_score", int'(p2_score), 0);
        check_val("reset_game_over", int'(game_over), 0);
        check_val("reset_winner", int'(winner), 0);
        check_pad("reset_pad1", 0, 204);
        check_pad("reset_pad2", 1, 204);

        for (int i = 0; i < 20; i++) begin
            probe(vecs[i].vo, vecs[i].px, vecs[i].py, c);
            total++;
            if (c !== vecs[i].exp) begin
                bad++;
                $display("FAIL pix[%0d] (%0d,%0d) vo=%0d: rgb %h expected %h",
                         i, vecs[i].px, vecs[i].py, vecs[i].vo, c, vecs[i].exp);
            end else begin
                $display("ok   pix[%0d] (%0d,%0d) vo=%0d rgb %h",
                         i, vecs[i].px, vecs[i].py, vecs[i].vo, c);
            end
        end

        // IDLE: buttons held, nothing moves and no serve starts.
        up1 = 1'b1; down2 = 1'b1;
        ticks(70);
        check_ball("idle_static", 316, 236);
        check_pad("idle_pad1", 0, 204);
        check_pad("idle_pad2", 1, 204);

        // Rally 1: serve right; paddle 1 parks at 0, paddle 2 at 408.
        pulse_start();
        ticks(60);
        check_ball("serve_static_60", 316, 236);
        check_pad("serve_pad1", 0, 24);
        check_pad("serve_pad2", 1, 384);
        tick();
        check_ball("first_play_tick", 318, 238);
        ticks(116);
        check_ball("wall_pre", 550, 470);
        tick();
        check_ball("wall_clamp", 552, 472);
        tick();
        check_ball("wall_after", 554, 470);
        ticks(21);
        check_ball("pad2_hit", 592, 428);
        ticks(296);
        check_val("pre_miss_p2_score", int'(p2_score), 0);
        tick();
        check_val("miss_p2_score", int'(p2_score), 1);
        check_val("miss_p1_score", int'(p1_score), 0);
        check_ball("miss_centred", 316, 236);
        check_pad("pad1_top0", 0, 0);
        check_pad("pad2_bottom", 1, 408);

        // Rally 2: serve left; paddle 1 moves down to 408 and returns it.
        up1 = 1'b0; down2 = 1'b0; down1 = 1'b1; up2 = 1'b1;
        ticks(60);
        check_ball("serve2_static", 316, 236);
        tick();
        check_ball("serve_left", 314, 238);
        ticks(139);
        check_ball("pad1_hit", 40, 428);
        check_val("hit_p1_score", int'(p1_score), 0);
        check_val("hit_p2_score", int'(p2_score), 1);
        check_pad("pad1_moved", 0, 408);
        check_pad("pad2_moved", 1, 0);
        ticks(297);
        check_val("rally2_p1_score", int'(p1_score), 1);
        check_val("rally2_p2_score", int'(p2_score), 1);

        // Rightward serves now always beat paddle 2 parked at the top.
        down1 = 1'b0; up2 = 1'b0;
        for (int r = 0; r < 7; r++) ticks(60 + 159);
        check_val("p1_eight", int'(p1_score), 8);
        check_val("not_over_yet", int'(game_over), 0);
        ticks(60 + 159);
        check_val("win_p1_score", int'(p1_score), 9);
        check_val("win_game_over", int'(game_over), 1);
        check_val("win_winner", int'(winner), 0);

        // OVER is frozen: frames and buttons change nothing.
        up1 = 1'b1;
        ticks(20);
        check_val("over_p1_hold", int'(p1_score), 9);
        check_val("over_p2_hold", int'(p2_score), 1);
        check_val("over_flag_hold", int'(game_over), 1);
        check_ball("over_centred", 316, 236);
        check_pad("over_pad1", 0, 408);

        // Restart, then both buttons together keep paddle 1 still.
        down1 = 1'b1;
        pulse_start();
        check_val("restart_p1", int'(p1_score), 0);
        check_val("restart_p2", int'(p2_score), 0);
        check_val("restart_over", int'(game_over), 0);
        ticks(10);
        check_pad("both_buttons", 0, 408);
        up1 = 1'b0; down1 = 1'b0;
        ticks(20);
        pulse_start();
        ticks(30);
        check_ball("restart_serve_static", 316, 236);
        tick();
        check_ball("restart_serve_dir", 318, 238);
        pulse_start();
        tick();
        check_ball("start_ignored_play", 320, 240);

        // Reset coincident with a frame tick during PLAY.
        @(negedge clk);
        x = 10'd0; y = 10'd481; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; x = 10'd1;
        check_val("mid_reset_p1", int'(p1_score), 0);
        check_val("mid_reset_over", int'(game_over), 0);
        check_ball("mid_reset_ball", 316, 236);
        check_pad("mid_reset_pad1", 0, 204);
        check_pad("mid_reset_pad2", 1, 204);
        ticks(70);
        check_ball("mid_reset_idle", 316, 236);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
